// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit.
// Holds the opcode constants, the sequencer state encoding, the bundled
// control-word type produced by the decoder, and a helper that gives the
// final execute step of each instruction class.
package cpu_pkg;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpJal  = 5'b10101;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpMfhi = 5'b11000;
  localparam logic [4:0] OpMflo = 5'b11001;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  // T0..T7 are consecutive so the sequencer can step by incrementing.
  typedef enum logic [3:0] {
    StReset = 4'd0,
    StT0    = 4'd1,
    StT1    = 4'd2,
    StT2    = 4'd3,
    StT3    = 4'd4,
    StT4    = 4'd5,
    StT5    = 4'd6,
    StT6    = 4'd7,
    StT7    = 4'd8,
    StHalt  = 4'd9
  } state_e;

  typedef struct packed {
    logic       ir_in;
    logic       pc_in;
    logic       ry_in;
    logic       rz_in;
    logic       mar_in;
    logic       mdr_in;
    logic       hi_in;
    logic       lo_in;
    logic       outport_in;
    logic       hi_out;
    logic       lo_out;
    logic       zhi_out;
    logic       zlo_out;
    logic       pc_out;
    logic       mdr_out;
    logic       inport_out;
    logic       c_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       inc_pc;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] alu_op;
  } ctrl_t;

  // Last execute step per opcode; anything unlisted (nop, jal, undefined) ends at T3.
  function automatic state_e last_step(input logic [4:0] op);
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl,
      OpAddi, OpAndi, OpOri, OpLdi:  last_step = StT5;
      OpLd, OpSt:                    last_step = StT7;
      OpMul, OpDiv, OpBr:            last_step = StT6;
      OpNeg, OpNot:                  last_step = StT4;
      default:                       last_step = StT3;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational Moore decoder for the control unit.
// Ports: i_state  - current sequencer state
//        i_opcode - ir[31:27]
//        i_taken  - branch decision captured at T3 of br
//        o_ctrl   - full control word (unlisted fields 0, alu_op defaults to ADD)
module control_decode
  import cpu_pkg::*;
(
  input  state_e     i_state,
  input  logic [4:0] i_opcode,
  input  logic       i_taken,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.alu_op = OpAdd;
    case (i_state)
      StT0: begin
        o_ctrl.pc_out = 1'b1; o_ctrl.mar_in = 1'b1; o_ctrl.inc_pc = 1'b1; o_ctrl.rz_in = 1'b1;
      end
      StT1: begin
        o_ctrl.zlo_out = 1'b1; o_ctrl.pc_in = 1'b1; o_ctrl.mem_read = 1'b1;
        o_ctrl.mdr_in = 1'b1;
      end
      StT2: begin
        o_ctrl.mdr_out = 1'b1; o_ctrl.ir_in = 1'b1;
      end
      StT3, StT4, StT5, StT6, StT7: begin
        case (i_opcode)
          OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl,
          OpAddi, OpAndi, OpOri: begin
            case (i_state)
              StT3: begin o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.ry_in = 1'b1; end
              StT4: begin
                // Immediate forms take the constant from the C field instead of Rc.
                if (i_opcode inside {OpAddi, OpAndi, OpOri}) begin
                  o_ctrl.c_out = 1'b1;
                end else begin
                  o_ctrl.grc = 1'b1; o_ctrl.r_out = 1'b1;
                end
                o_ctrl.rz_in  = 1'b1;
                o_ctrl.alu_op = i_opcode;
              end
              StT5: begin o_ctrl.zlo_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          OpLd, OpLdi, OpSt: begin
            case (i_state)
              StT3: begin o_ctrl.grb = 1'b1; o_ctrl.ba_out = 1'b1; o_ctrl.ry_in = 1'b1; end
              StT4: begin o_ctrl.c_out = 1'b1; o_ctrl.rz_in = 1'b1; end
              StT5: begin
                o_ctrl.zlo_out = 1'b1;
                if (i_opcode == OpLdi) begin
                  o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                end else begin
                  o_ctrl.mar_in = 1'b1;
                end
              end
              StT6: begin
                o_ctrl.mdr_in = 1'b1;
                if (i_opcode == OpSt) begin
                  o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1;
                end else begin
                  o_ctrl.mem_read = 1'b1;
                end
              end
              StT7: begin
                if (i_opcode == OpSt) begin
                  o_ctrl.mem_write = 1'b1;
                end else begin
                  o_ctrl.mdr_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OpMul, OpDiv: begin
            case (i_state)
              StT3: begin o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.ry_in = 1'b1; end
              StT4: begin
                o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.rz_in = 1'b1;
                o_ctrl.alu_op = i_opcode;
              end
              StT5: begin o_ctrl.zlo_out = 1'b1; o_ctrl.lo_in = 1'b1; end
              StT6: begin o_ctrl.zhi_out = 1'b1; o_ctrl.hi_in = 1'b1; end
              default: ;
            endcase
          end
          OpNeg, OpNot: begin
            case (i_state)
              StT3: begin
                o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.rz_in = 1'b1;
                o_ctrl.alu_op = i_opcode;
              end
              StT4: begin o_ctrl.zlo_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1; end
              default: ;
            endcase
          end
          OpBr: begin
            case (i_state)
              StT3: begin o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; end
              StT4: begin o_ctrl.pc_out = 1'b1; o_ctrl.ry_in = 1'b1; end
              StT5: begin o_ctrl.c_out = 1'b1; o_ctrl.rz_in = 1'b1; end
              StT6: begin o_ctrl.zlo_out = i_taken; o_ctrl.pc_in = i_taken; end
              default: ;
            endcase
          end
          OpJr: if (i_state == StT3) begin
            o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.pc_in = 1'b1;
          end
          OpIn: if (i_state == StT3) begin
            o_ctrl.inport_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
          end
          OpOut: if (i_state == StT3) begin
            o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.outport_in = 1'b1;
          end
          OpMfhi: if (i_state == StT3) begin
            o_ctrl.hi_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
          end
          OpMflo: if (i_state == StT3) begin
            o_ctrl.lo_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit sequencer.
// Ports: clock, clear (sync active-low), ir (opcode = ir[31:27]), con_ff_bit
//        (branch condition), stop (halt at next instruction boundary);
//        outputs are register enables, bus selects, decoder/ALU/memory
//        controls, alu_op, and run (high while sequencing).
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff_bit,
  input  logic        stop,
  output logic        IRin,
  output logic        PCin,
  output logic        RYin,
  output logic        RZin,
  output logic        MARin,
  output logic        MDRin,
  output logic        HIin,
  output logic        LOin,
  output logic        Outport_in,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhi_out,
  output logic        Zlo_out,
  output logic        PCout,
  output logic        MDRout,
  output logic        Inport_out,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        IncPC,
  output logic        Mem_read,
  output logic        Mem_write,
  output logic [4:0]  alu_op,
  output logic        run
);

  state_e     r_state;
  logic       r_taken;
  logic [4:0] w_opcode;
  state_e     w_last;
  ctrl_t      w_ctrl;
  logic       w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_last      = last_step(w_opcode);
  assign w_unused_ir = ^ir[26:0];

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state <= StReset;
      r_taken <= 1'b0;
    end else begin
      if (r_state == StT3 && w_opcode == OpBr) begin
        r_taken <= con_ff_bit;
      end
      case (r_state)
        StReset: r_state <= StT0;
        StT0:    r_state <= StT1;
        StT1:    r_state <= StT2;
        StT2:    r_state <= StT3;
        StT3, StT4, StT5, StT6, StT7: begin
          if (r_state == StT3 && w_opcode == OpHalt) begin
            r_state <= StHalt;
          end else if (r_state == w_last) begin
            // Instruction boundary: the only point where stop is honoured.
            r_state <= stop ? StHalt : StT0;
          end else begin
            r_state <= state_e'(r_state + 4'd1);
          end
        end
        StHalt:  r_state <= StHalt;
        default: r_state <= StReset;
      endcase
    end
  end

  control_decode u_decode (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_taken  (r_taken),
    .o_ctrl   (w_ctrl)
  );

  assign IRin       = w_ctrl.ir_in;
  assign PCin       = w_ctrl.pc_in;
  assign RYin       = w_ctrl.ry_in;
  assign RZin       = w_ctrl.rz_in;
  assign MARin      = w_ctrl.mar_in;
  assign MDRin      = w_ctrl.mdr_in;
  assign HIin       = w_ctrl.hi_in;
  assign LOin       = w_ctrl.lo_in;
  assign Outport_in = w_ctrl.outport_in;
  assign HIout      = w_ctrl.hi_out;
  assign LOout      = w_ctrl.lo_out;
  assign Zhi_out    = w_ctrl.zhi_out;
  assign Zlo_out    = w_ctrl.zlo_out;
  assign PCout      = w_ctrl.pc_out;
  assign MDRout     = w_ctrl.mdr_out;
  assign Inport_out = w_ctrl.inport_out;
  assign Cout       = w_ctrl.c_out;
  assign Gra        = w_ctrl.gra;
  assign Grb        = w_ctrl.grb;
  assign Grc        = w_ctrl.grc;
  assign Rin        = w_ctrl.r_in;
  assign Rout       = w_ctrl.r_out;
  assign BAout      = w_ctrl.ba_out;
  assign IncPC      = w_ctrl.inc_pc;
  assign Mem_read   = w_ctrl.mem_read;
  assign Mem_write  = w_ctrl.mem_write;
  assign alu_op     = w_ctrl.alu_op;
  assign run        = (r_state != StReset) && (r_state != StHalt);

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: per-step enable sets for a
// range of instruction classes, branch taken/not-taken, stop and clear timing.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = '0;
  logic        con_ff_bit = 1'b0;
  logic        stop = 1'b0;
  logic        IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Mem_read, Mem_write;
  logic [4:0]  alu_op;
  logic        run;

  always #5 clock = ~clock;

  control_unit u_dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff_bit(con_ff_bit), .stop(stop),
    .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in), .HIout(HIout), .LOout(LOout),
    .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout), .MDRout(MDRout),
    .Inport_out(Inport_out), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .IncPC(IncPC), .Mem_read(Mem_read),
    .Mem_write(Mem_write), .alu_op(alu_op), .run(run)
  );

  logic [25:0] en;
  assign en = {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, HIout, LOout,
               Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Gra, Grb, Grc, Rin, Rout,
               BAout, IncPC, Mem_read, Mem_write};

  localparam logic [25:0] EnMemWrite = 26'd1 << 0;
  localparam logic [25:0] EnMemRead  = 26'd1 << 1;
  localparam logic [25:0] EnIncPc    = 26'd1 << 2;
  localparam logic [25:0] EnBaOut    = 26'd1 << 3;
  localparam logic [25:0] EnRout     = 26'd1 << 4;
  localparam logic [25:0] EnRin      = 26'd1 << 5;
  localparam logic [25:0] EnGrc      = 26'd1 << 6;
  localparam logic [25:0] EnGrb      = 26'd1 << 7;
  localparam logic [25:0] EnGra      = 26'd1 << 8;
  localparam logic [25:0] EnCout     = 26'd1 << 9;
  localparam logic [25:0] EnInpOut   = 26'd1 << 10;
  localparam logic [25:0] EnMdrOut   = 26'd1 << 11;
  localparam logic [25:0] EnPcOut    = 26'd1 << 12;
  localparam logic [25:0] EnZloOut   = 26'd1 << 13;
  localparam logic [25:0] EnZhiOut   = 26'd1 << 14;
  localparam logic [25:0] EnLoOut    = 26'd1 << 15;
  localparam logic [25:0] EnHiOut    = 26'd1 << 16;
  localparam logic [25:0] EnOutpIn   = 26'd1 << 17;
  localparam logic [25:0] EnLoIn     = 26'd1 << 18;
  localparam logic [25:0] EnHiIn     = 26'd1 << 19;
  localparam logic [25:0] EnMdrIn    = 26'd1 << 20;
  localparam logic [25:0] EnMarIn    = 26'd1 << 21;
  localparam logic [25:0] EnRzIn     = 26'd1 << 22;
  localparam logic [25:0] EnRyIn     = 26'd1 << 23;
  localparam logic [25:0] EnPcIn     = 26'd1 << 24;
  localparam logic [25:0] EnIrIn     = 26'd1 << 25;

  localparam logic [25:0] FetchT0 = EnPcOut | EnMarIn | EnIncPc | EnRzIn;
  localparam logic [25:0] FetchT1 = EnZloOut | EnPcIn | EnMemRead | EnMdrIn;
  localparam logic [25:0] FetchT2 = EnMdrOut | EnIrIn;
  localparam logic [4:0]  AluAdd  = 5'b00011;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_on = 1'b0;
  logic [25:0] exp_en [8];
  logic [4:0]  exp_alu [8];
  logic        con_seq [8];
  logic        stop_seq [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic prep();
    for (int i = 0; i < 8; i++) begin
      exp_en[i]   = '0;
      exp_alu[i]  = AluAdd;
      con_seq[i]  = 1'b0;
      stop_seq[i] = 1'b0;
    end
    exp_en[0] = FetchT0;
    exp_en[1] = FetchT1;
    exp_en[2] = FetchT2;
  endtask

  // Walks n cycles from T0, checking each step, then advances past the last one.
  task automatic exec(input string tag, input logic [31:0] instr, input int n);
    ir = instr;
    for (int i = 0; i < n; i++) begin
      con_ff_bit = con_seq[i];
      stop       = stop_seq[i];
      check($sformatf("%s_t%0d_en", tag, i), 32'(en), 32'(exp_en[i]));
      check($sformatf("%s_t%0d_alu", tag, i), 32'(alu_op), 32'(exp_alu[i]));
      check($sformatf("%s_t%0d_run", tag, i), 32'(run), 32'd1);
      tick();
    end
    con_ff_bit = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic expect_t0(input string tag);
    check({tag, "_t0_en"}, 32'(en), 32'(FetchT0));
    check({tag, "_t0_run"}, 32'(run), 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_en"}, 32'(en), 32'd0);
    check({tag, "_run"}, 32'(run), 32'd0);
    check({tag, "_alu"}, 32'(alu_op), 32'(AluAdd));
  endtask

  always @(negedge clock) begin
    if (mon_on) check("mem_excl", 32'(Mem_read & Mem_write), 32'd0);
  end

  initial begin
    // Reset held for two edges, then released.
    tick();
    expect_idle("rst1");
    tick();
    expect_idle("rst2");
    clear = 1'b1;
    tick();
    expect_t0("rel");
    mon_on = 1'b1;

    // add r1, r2, r3
    prep();
    exp_en[3] = EnGrb | EnRout | EnRyIn;
    exp_en[4] = EnGrc | EnRout | EnRzIn;
    exp_en[5] = EnZloOut | EnGra | EnRin;
    exec("add", 32'h1891_8000, 6);
    expect_t0("add_end");

    // sub: same shape, ALU code follows the opcode
    exp_alu[4] = 5'b00100;
    exec("sub", 32'h2000_0000, 6);
    expect_t0("sub_end");

    // addi: constant replaces Rc at T4
    prep();
    exp_en[3] = EnGrb | EnRout | EnRyIn;
    exp_en[4] = EnCout | EnRzIn;
    exp_alu[4] = 5'b01100;
    exp_en[5] = EnZloOut | EnGra | EnRin;
    exec("addi", 32'h6000_0000, 6);
    expect_t0("addi_end");

    // br taken
    prep();
    exp_en[3] = EnGra | EnRout;
    exp_en[4] = EnPcOut | EnRyIn;
    exp_en[5] = EnCout | EnRzIn;
    exp_en[6] = EnZloOut | EnPcIn;
    for (int i = 0; i < 8; i++) con_seq[i] = 1'b1;
    exec("br_tk", 32'h9800_0000, 7);
    expect_t0("br_tk_end");

    // br not taken: condition low only at T3, high afterwards
    exp_en[6] = '0;
    con_seq[3] = 1'b0;
    exec("br_nt", 32'h9800_0000, 7);
    expect_t0("br_nt_end");

    // st
    prep();
    exp_en[3] = EnGrb | EnBaOut | EnRyIn;
    exp_en[4] = EnCout | EnRzIn;
    exp_en[5] = EnZloOut | EnMarIn;
    exp_en[6] = EnGra | EnRout | EnMdrIn;
    exp_en[7] = EnMemWrite;
    exec("st", 32'h1000_0000, 8);
    expect_t0("st_end");

    // mul
    prep();
    exp_en[3] = EnGra | EnRout | EnRyIn;
    exp_en[4] = EnGrb | EnRout | EnRzIn;
    exp_alu[4] = 5'b10000;
    exp_en[5] = EnZloOut | EnLoIn;
    exp_en[6] = EnZhiOut | EnHiIn;
    exec("mul", 32'h8000_0000, 7);
    expect_t0("mul_end");

    // neg
    prep();
    exp_en[3] = EnGrb | EnRout | EnRzIn;
    exp_alu[3] = 5'b10001;
    exp_en[4] = EnZloOut | EnGra | EnRin;
    exec("neg", 32'h8800_0000, 5);
    expect_t0("neg_end");

    // single-step ops and nop
    prep();
    exp_en[3] = EnGra | EnRout | EnPcIn;
    exec("jr", 32'hA000_0000, 4);
    expect_t0("jr_end");
    exp_en[3] = EnHiOut | EnGra | EnRin;
    exec("mfhi", 32'hC000_0000, 4);
    expect_t0("mfhi_end");
    exp_en[3] = EnGra | EnRout | EnOutpIn;
    exec("out", 32'hB800_0000, 4);
    expect_t0("out_end");
    exp_en[3] = '0;
    exec("nop", 32'hD000_0000, 4);
    expect_t0("nop_end");

    // ld with stop raised at T4 and held: completes, then halts
    prep();
    exp_en[3] = EnGrb | EnBaOut | EnRyIn;
    exp_en[4] = EnCout | EnRzIn;
    exp_en[5] = EnZloOut | EnMarIn;
    exp_en[6] = EnMemRead | EnMdrIn;
    exp_en[7] = EnMdrOut | EnGra | EnRin;
    for (int i = 4; i < 8; i++) stop_seq[i] = 1'b1;
    exec("ld_stop", 32'h0000_0000, 8);
    expect_idle("ld_halt");
    tick();
    expect_idle("ld_halt2");
    clear = 1'b0;
    tick();
    expect_idle("ld_rst");
    clear = 1'b1;
    tick();
    expect_t0("ld_rel");

    // second ld, cleared at T5
    for (int i = 4; i < 8; i++) stop_seq[i] = 1'b0;
    exec("ld_clr", 32'h0000_0000, 5);
    check("ld_clr_t5_en", 32'(en), 32'(EnZloOut | EnMarIn));
    clear = 1'b0;
    tick();
    expect_idle("ld_clr_rst");
    clear = 1'b1;
    tick();
    expect_t0("ld_clr_rel");

    // halt opcode: T3 idle, then HALT held
    prep();
    exec("halt", 32'hD800_0000, 4);
    for (int i = 0; i < 20; i++) begin
      expect_idle($sformatf("halt_hold%0d", i));
      tick();
    end

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
